// File: rtl/gpo_pad_ctrl_pkg.sv
// Shared types and encodings for the GPO pad controller: FSM states,
// pad mode / drive-strength codes and the mode-to-pad-disable mapping.
package gpo_pad_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_ACTIVE    = 3'd0,
        ST_QUIESCE   = 3'd1,
        ST_APPLY     = 3'd2,
        ST_WAIT_BIAS = 3'd3,
        ST_SETTLE    = 3'd4
    } gpo_state_e;

    localparam logic [1:0] MODE_PP  = 2'b00;
    localparam logic [1:0] MODE_OD  = 2'b01;
    localparam logic [1:0] MODE_OS  = 2'b10;
    localparam logic [1:0] MODE_DIS = 2'b11;

    localparam logic [1:0] DS_OFF  = 2'b00;
    localparam logic [1:0] DS_LOW  = 2'b01;
    localparam logic [1:0] DS_MID  = 2'b10;
    localparam logic [1:0] DS_HIGH = 2'b11;

    localparam int SETTLE_W = 8;
    localparam int BIAS_W   = 16;

    // Returns {odp, odn}: odp disables the high-side driver, odn the low-side one.
    function automatic logic [1:0] mode_to_od(input logic [1:0] mode);
        logic [1:0] od;
        case (mode)
            MODE_PP:  od = 2'b00;
            MODE_OD:  od = 2'b10;
            MODE_OS:  od = 2'b01;
            MODE_DIS: od = 2'b11;
            default:  od = 2'b11;
        endcase
        return od;
    endfunction

endpackage

// File: rtl/gpo_pad_ctrl_sync.sv
// Two-flop synchroniser for single-bit asynchronous status inputs.
module gpo_sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Double-register the asynchronous input, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/gpo_pad_ctrl.sv
// GPO pad controller: sequences pad reconfiguration with OE quiet windows,
// waits for the bias generator and flags bias faults.
module gpo_pad_ctrl
    import gpo_pad_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned BIAS_TO    = 255
) (
    input  logic       CLK_I,
    input  logic       RSTN_I,
    input  logic       CFG_VALID_I,
    output logic       CFG_READY_O,
    input  logic [1:0] CFG_DS_I,
    input  logic       CFG_SR_I,
    input  logic       CFG_CO_I,
    input  logic [1:0] CFG_MODE_I,
    input  logic       DATA_I,
    input  logic       EN_I,
    input  logic       BIAS_OK_I,
    output logic       DO_O,
    output logic       SR_O,
    output logic       CO_O,
    output logic       OE_O,
    output logic       ODP_O,
    output logic       ODN_O,
    output logic [1:0] DS_O,
    output logic       BUSY_O,
    output logic       BIAS_ERR_O
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [BIAS_W-1:0]   BIAS_LAST   = BIAS_W'(BIAS_TO - 1);

    gpo_state_e            state_r, state_next_s;
    logic [SETTLE_W-1:0]   settle_cnt_r;
    logic [BIAS_W-1:0]     bias_cnt_r;
    logic [1:0]            cap_ds_r, cap_mode_r;
    logic                  cap_sr_r, cap_co_r;
    logic [1:0]            ds_r;
    logic                  sr_r, co_r, do_r, oe_r, odp_r, odn_r;
    logic                  err_r, ready_r, busy_r;
    logic                  bias_s, accept_s, settle_done_s, bias_to_s, timeout_s;

    gpo_sync2 u_bias_sync (
        .clk  (CLK_I),
        .rstn (RSTN_I),
        .d    (BIAS_OK_I),
        .q    (bias_s)
    );

    // Next-state decode and per-cycle event flags.
    always_comb begin
        state_next_s  = state_r;
        accept_s      = CFG_VALID_I & ready_r;
        settle_done_s = (settle_cnt_r == SETTLE_LAST);
        bias_to_s     = (bias_cnt_r == BIAS_LAST);
        timeout_s     = (state_r == ST_WAIT_BIAS) & ~bias_s & bias_to_s;
        case (state_r)
            ST_ACTIVE: begin
                if (accept_s) state_next_s = ST_QUIESCE;
                else          state_next_s = ST_ACTIVE;
            end
            ST_QUIESCE: begin
                if (settle_done_s) state_next_s = ST_APPLY;
                else               state_next_s = ST_QUIESCE;
            end
            ST_APPLY: begin
                if (cap_ds_r != DS_OFF) state_next_s = ST_WAIT_BIAS;
                else                    state_next_s = ST_SETTLE;
            end
            ST_WAIT_BIAS: begin
                if (bias_s || bias_to_s) state_next_s = ST_SETTLE;
                else                     state_next_s = ST_WAIT_BIAS;
            end
            ST_SETTLE: begin
                if (settle_done_s) state_next_s = ST_ACTIVE;
                else               state_next_s = ST_SETTLE;
            end
            default: state_next_s = ST_ACTIVE;
        endcase
    end

    // State register, handshake flags and the settle / bias-timeout counters.
    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            state_r      <= ST_ACTIVE;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            settle_cnt_r <= '0;
            bias_cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_ACTIVE);
            busy_r  <= (state_next_s != ST_ACTIVE);
            if ((state_r == ST_QUIESCE || state_r == ST_SETTLE) && !settle_done_s)
                settle_cnt_r <= settle_cnt_r + 8'd1;
            else
                settle_cnt_r <= '0;
            if (state_r == ST_WAIT_BIAS && !bias_s && !bias_to_s)
                bias_cnt_r <= bias_cnt_r + 16'd1;
            else
                bias_cnt_r <= '0;
        end
    end

    // Request capture and pad configuration; a bias timeout strips the drive strength.
    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            cap_ds_r   <= DS_OFF;
            cap_sr_r   <= 1'b0;
            cap_co_r   <= 1'b0;
            cap_mode_r <= MODE_PP;
            ds_r       <= DS_OFF;
            sr_r       <= 1'b0;
            co_r       <= 1'b0;
            odp_r      <= 1'b0;
            odn_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                cap_ds_r   <= CFG_DS_I;
                cap_sr_r   <= CFG_SR_I;
                cap_co_r   <= CFG_CO_I;
                cap_mode_r <= CFG_MODE_I;
            end
            if (state_r == ST_APPLY) begin
                ds_r           <= cap_ds_r;
                sr_r           <= cap_sr_r;
                co_r           <= cap_co_r;
                {odp_r, odn_r} <= mode_to_od(cap_mode_r);
            end else if (timeout_s) begin
                ds_r <= DS_OFF;
            end
        end
    end

    // Data path, output enable gating and the sticky bias fault (accept clears first).
    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            do_r  <= 1'b0;
            oe_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            do_r <= DATA_I;
            if (state_r == ST_ACTIVE && !accept_s)
                oe_r <= EN_I & ((ds_r == DS_OFF) | bias_s);
            else
                oe_r <= 1'b0;
            if (accept_s)
                err_r <= 1'b0;
            else if (state_r == ST_ACTIVE && ds_r != DS_OFF && !bias_s)
                err_r <= 1'b1;
            else if (timeout_s)
                err_r <= 1'b1;
        end
    end

    assign CFG_READY_O = ready_r;
    assign BUSY_O      = busy_r;
    assign BIAS_ERR_O  = err_r;
    assign DO_O        = do_r;
    assign OE_O        = oe_r;
    assign SR_O        = sr_r;
    assign CO_O        = co_r;
    assign ODP_O       = odp_r;
    assign ODN_O       = odn_r;
    assign DS_O        = ds_r;

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// Self-checking bench for gpo_pad_ctrl: randomized data/requests checked against
// timing and mapping rules computed directly from the pad controller behaviour.
module tb_gpo_pad_ctrl;

    localparam int SC = 4;
    localparam int BT = 16;

    logic       CLK_I = 1'b0;
    logic       RSTN_I = 1'b0;
    logic       CFG_VALID_I = 1'b0;
    logic       CFG_READY_O;
    logic [1:0] CFG_DS_I = 2'b00;
    logic       CFG_SR_I = 1'b0;
    logic       CFG_CO_I = 1'b0;
    logic [1:0] CFG_MODE_I = 2'b00;
    logic       DATA_I = 1'b0;
    logic       EN_I = 1'b0;
    logic       BIAS_OK_I = 1'b0;
    logic       DO_O, SR_O, CO_O, OE_O, ODP_O, ODN_O, BUSY_O, BIAS_ERR_O;
    logic [1:0] DS_O;

    int checks = 0;
    int errors = 0;

    // {ODP, ODN} per mode: push-pull, open-drain, open-source, disabled
    logic [1:0] od_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

    gpo_pad_ctrl #(.SETTLE_CYC(SC), .BIAS_TO(BT)) dut (
        .CLK_I(CLK_I), .RSTN_I(RSTN_I), .CFG_VALID_I(CFG_VALID_I), .CFG_READY_O(CFG_READY_O),
        .CFG_DS_I(CFG_DS_I), .CFG_SR_I(CFG_SR_I), .CFG_CO_I(CFG_CO_I), .CFG_MODE_I(CFG_MODE_I),
        .DATA_I(DATA_I), .EN_I(EN_I), .BIAS_OK_I(BIAS_OK_I), .DO_O(DO_O), .SR_O(SR_O),
        .CO_O(CO_O), .OE_O(OE_O), .ODP_O(ODP_O), .ODN_O(ODN_O), .DS_O(DS_O),
        .BUSY_O(BUSY_O), .BIAS_ERR_O(BIAS_ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic cyc();
        @(posedge CLK_I);
        #1;
    endtask

    // Issue one request; afterwards the bench sits in the first ACTIVE cycle.
    task automatic do_request(input logic [1:0] ds, input logic sr, input logic co,
                              input logic [1:0] mode, input int hold,
                              output int busy_n, output int ds_n, output int oe_n);
        busy_n = 0; ds_n = 0; oe_n = 0;
        CFG_DS_I = ds; CFG_SR_I = sr; CFG_CO_I = co; CFG_MODE_I = mode;
        CFG_VALID_I = 1'b1;
        cyc();
        CFG_DS_I = ~ds; CFG_SR_I = ~sr; CFG_CO_I = ~co; CFG_MODE_I = ~mode;
        if (hold == 0) CFG_VALID_I = 1'b0;
        while (BUSY_O === 1'b1 && busy_n < 1000) begin
            if (busy_n >= hold) CFG_VALID_I = 1'b0;
            busy_n++;
            if (DS_O === ds) ds_n++;
            if (OE_O !== 1'b0) oe_n++;
            cyc();
        end
        CFG_VALID_I = 1'b0;
    endtask

    task automatic test_reset();
        RSTN_I = 1'b0; DATA_I = 1'b1; EN_I = 1'b1; BIAS_OK_I = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({DO_O, SR_O, CO_O, OE_O, ODP_O, ODN_O, DS_O, BUSY_O, BIAS_ERR_O, CFG_READY_O} !== 11'b00000000001) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                {DO_O, SR_O, CO_O, OE_O, ODP_O, ODN_O, DS_O, BUSY_O, BIAS_ERR_O, CFG_READY_O}, 11'b00000000001);
        end
        RSTN_I = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic test_data_path(input int n);
        logic d, e;
        for (int i = 0; i < n; i++) begin
            d = 1'($urandom); e = (i < 4) ? 1'b1 : 1'($urandom);
            DATA_I = d; EN_I = e;
            cyc();
            checks++;
            if (DO_O !== d || OE_O !== e) begin
                errors++;
                $display("FAIL data_path[%0d]: got DO=%b OE=%b expected DO=%b OE=%b", i, DO_O, OE_O, d, e);
            end
        end
        EN_I = 1'b1;
        cyc();
    endtask

    task automatic test_reconfig_bias_ok();
        int b, dn, on;
        checks++;
        if (OE_O !== 1'b1) begin errors++; $display("FAIL pre_oe: got %b expected 1", OE_O); end
        do_request(2'b10, 1'b1, 1'b0, 2'b00, 0, b, dn, on);
        checks++;
        if (b !== 2*SC + 2 || on !== 0) begin
            errors++; $display("FAIL reconfig_busy: got busy=%0d oe_high=%0d expected busy=%0d oe_high=0", b, on, 2*SC + 2);
        end
        checks++;
        if ({DS_O, SR_O, CO_O, ODP_O, ODN_O, BIAS_ERR_O, CFG_READY_O, OE_O} !== {2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reconfig_cfg: got %b expected %b",
                {DS_O, SR_O, CO_O, ODP_O, ODN_O, BIAS_ERR_O, CFG_READY_O, OE_O}, 9'b101000010);
        end
        cyc();
        checks++;
        if (OE_O !== 1'b1) begin errors++; $display("FAIL reconfig_oe_resume: got %b expected 1", OE_O); end
    endtask

    task automatic test_bias_loss();
        int b, dn, on;
        do_request(2'b01, 1'b0, 1'b1, 2'b00, 0, b, dn, on);
        cyc();
        checks++;
        if (OE_O !== 1'b1) begin errors++; $display("FAIL loss_pre_oe: got %b expected 1", OE_O); end
        BIAS_OK_I = 1'b0;
        repeat (2) cyc();
        checks++;
        if (OE_O !== 1'b1 || BIAS_ERR_O !== 1'b0) begin
            errors++; $display("FAIL loss_early: got OE=%b ERR=%b expected OE=1 ERR=0", OE_O, BIAS_ERR_O);
        end
        cyc();
        checks++;
        if (OE_O !== 1'b0 || BIAS_ERR_O !== 1'b1 || DS_O !== 2'b01) begin
            errors++; $display("FAIL loss_3cyc: got OE=%b ERR=%b DS=%b expected OE=0 ERR=1 DS=01", OE_O, BIAS_ERR_O, DS_O);
        end
        BIAS_OK_I = 1'b1;
        repeat (2) cyc();
        checks++;
        if (OE_O !== 1'b0) begin errors++; $display("FAIL restore_early: got OE=%b expected 0", OE_O); end
        cyc();
        checks++;
        if (OE_O !== 1'b1 || BIAS_ERR_O !== 1'b1) begin
            errors++; $display("FAIL restore_3cyc: got OE=%b ERR=%b expected OE=1 ERR=1", OE_O, BIAS_ERR_O);
        end
    endtask

    task automatic test_modes_ignore();
        int b, dn, on;
        do_request(2'b00, 1'b1, 1'b1, 2'b01, 3, b, dn, on);
        checks++;
        if (b !== 2*SC + 1 || {ODP_O, ODN_O, DS_O, SR_O, CO_O, BIAS_ERR_O} !== 7'b1000110) begin
            errors++; $display("FAIL mode01: got busy=%0d bits=%b expected busy=%0d bits=1000110",
                b, {ODP_O, ODN_O, DS_O, SR_O, CO_O, BIAS_ERR_O}, 2*SC + 1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (BUSY_O !== 1'b0 || CFG_READY_O !== 1'b1) begin
                errors++; $display("FAIL no_queue[%0d]: got BUSY=%b READY=%b expected 0 1", i, BUSY_O, CFG_READY_O);
            end
        end
        do_request(2'b11, 1'b0, 1'b0, 2'b11, 2, b, dn, on);
        checks++;
        if (b !== 2*SC + 2 || {ODP_O, ODN_O, DS_O, SR_O, CO_O} !== 6'b111100) begin
            errors++; $display("FAIL mode11: got busy=%0d bits=%b expected busy=%0d bits=111100",
                b, {ODP_O, ODN_O, DS_O, SR_O, CO_O}, 2*SC + 2);
        end
    endtask

    task automatic test_random_reqs(input int n);
        int b, dn, on, exp_b;
        logic [1:0] ds, mode;
        logic sr, co;
        for (int i = 0; i < n; i++) begin
            ds = 2'($urandom); mode = 2'($urandom); sr = 1'($urandom); co = 1'($urandom);
            exp_b = 2*SC + 1 + ((ds != 2'b00) ? 1 : 0);
            do_request(ds, sr, co, mode, int'($urandom_range(0, 3)), b, dn, on);
            checks++;
            if (b !== exp_b || on !== 0 ||
                {DS_O, SR_O, CO_O, ODP_O, ODN_O, BIAS_ERR_O, CFG_READY_O} !== {ds, sr, co, od_tab[mode], 1'b0, 1'b1}) begin
                errors++; $display("FAIL rand_req[%0d]: got busy=%0d oe_high=%0d cfg=%b expected busy=%0d oe_high=0 cfg=%b",
                    i, b, on, {DS_O, SR_O, CO_O, ODP_O, ODN_O, BIAS_ERR_O, CFG_READY_O},
                    exp_b, {ds, sr, co, od_tab[mode], 1'b0, 1'b1});
            end
            cyc();
        end
    endtask

    task automatic test_bias_timeout();
        int b, dn, on;
        do_request(2'b00, 1'b0, 1'b0, 2'b00, 0, b, dn, on);
        BIAS_OK_I = 1'b0;
        repeat (3) cyc();
        do_request(2'b11, 1'b1, 1'b0, 2'b10, 0, b, dn, on);
        checks++;
        if (b !== 2*SC + 1 + BT || dn !== BT) begin
            errors++; $display("FAIL timeout_len: got busy=%0d ds11=%0d expected busy=%0d ds11=%0d", b, dn, 2*SC + 1 + BT, BT);
        end
        checks++;
        if ({DS_O, BIAS_ERR_O, ODP_O, ODN_O} !== 5'b00101) begin
            errors++; $display("FAIL timeout_state: got %b expected 00101", {DS_O, BIAS_ERR_O, ODP_O, ODN_O});
        end
        do_request(2'b00, 1'b0, 1'b0, 2'b00, 0, b, dn, on);
        checks++;
        if (BIAS_ERR_O !== 1'b0 || b !== 2*SC + 1) begin
            errors++; $display("FAIL err_clear: got ERR=%b busy=%0d expected ERR=0 busy=%0d", BIAS_ERR_O, b, 2*SC + 1);
        end
    endtask

    task automatic test_reset_mid();
        DATA_I = 1'b1; EN_I = 1'b1;
        CFG_DS_I = 2'b10; CFG_MODE_I = 2'b11; CFG_SR_I = 1'b1; CFG_CO_I = 1'b1;
        CFG_VALID_I = 1'b1;
        cyc();
        CFG_VALID_I = 1'b0;
        repeat (SC + 3) cyc();
        checks++;
        if (BUSY_O !== 1'b1 || DS_O !== 2'b10) begin
            errors++; $display("FAIL wait_bias_pre: got BUSY=%b DS=%b expected 1 10", BUSY_O, DS_O);
        end
        RSTN_I = 1'b0;
        cyc();
        checks++;
        if ({DO_O, SR_O, CO_O, OE_O, ODP_O, ODN_O, DS_O, BUSY_O, BIAS_ERR_O, CFG_READY_O} !== 11'b00000000001) begin
            errors++; $display("FAIL reset_mid: got %b expected %b",
                {DO_O, SR_O, CO_O, OE_O, ODP_O, ODN_O, DS_O, BUSY_O, BIAS_ERR_O, CFG_READY_O}, 11'b00000000001);
        end
        RSTN_I = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_data_path(30);
        test_reconfig_bias_ok();
        test_bias_loss();
        test_modes_ignore();
        test_random_reqs(8);
        test_bias_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpo_pad_ctrl.md
GPO_PAD_CTRL -- requirements
Module: gpo_pad_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE_CYC, default 4: cycles OE_O is held low before and after a pad configuration change (legal 1..255).
REQ-002 SHALL provide parameter BIAS_TO, default 255: maximum cycles to wait for bias-good after a non-zero drive strength is applied (legal 1..65535).
REQ-003 SHALL use one clock and a synchronous, active-low reset: CLK_I  in  1  sole clock, all logic rising-edge.
REQ-004 RSTN_I  in  1  synchronous active-low reset.
REQ-005 CFG_VALID_I  in  1  configuration request valid.
REQ-006 CFG_READY_O  out  1  configuration request accepted when high with CFG_VALID_I.
REQ-007 CFG_DS_I  in  2  requested drive strength.
REQ-008 CFG_SR_I / CFG_CO_I  in  1 each  requested slew-rate / CO setting.
REQ-009 CFG_MODE_I  in  2  00 push-pull, 01 open-drain, 10 open-source, 11 disabled.
REQ-010 DATA_I / EN_I  in  1 each  core output value / core output enable.
REQ-011 BIAS_OK_I  in  1  asynchronous bias-good indication from the pad bias generator.
REQ-012 DO_O, SR_O, CO_O, OE_O, ODP_O, ODN_O  out  1 each; DS_O  out  2: pad-cell controls.
REQ-013 BUSY_O  out  1  reconfiguration in progress; BIAS_ERR_O  out  1  sticky bias fault.

Function
REQ-014 SHALL synchronise BIAS_OK_I through two flops (bias_s); all uses refer to bias_s.
REQ-015 FSM states SHALL be ACTIVE, QUIESCE, APPLY, WAIT_BIAS, SETTLE; CFG_READY_O=1 only in ACTIVE; BUSY_O=1 in all other states.
REQ-016 ACTIVE -> QUIESCE on CFG_VALID_I&CFG_READY_O; request fields captured that cycle.
REQ-017 QUIESCE SHALL last exactly SETTLE_CYC cycles with OE_O=0, then -> APPLY.
REQ-018 APPLY (1 cycle) SHALL update DS_O, SR_O, CO_O, ODP_O, ODN_O from captured fields; -> WAIT_BIAS if captured DS!=00, else -> SETTLE.
REQ-019 Mode mapping: 00 ODP=0,ODN=0; 01 ODP=1,ODN=0; 10 ODP=0,ODN=1; 11 ODP=1,ODN=1 (pad never driven).
REQ-020 WAIT_BIAS -> SETTLE when bias_s=1; if BIAS_TO cycles elapse first, DS_O SHALL be forced to 00, BIAS_ERR_O set, -> SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles with OE_O=0, then -> ACTIVE.
REQ-022 In ACTIVE, OE_O SHALL be registered EN_I & (DS_O==00 | bias_s); DO_O SHALL be registered DATA_I in all states (1-cycle latency).
REQ-023 Bias loss in ACTIVE with DS_O!=00 SHALL force OE_O=0 from the next cycle and set BIAS_ERR_O; DS_O unchanged; OE_O resumes when bias_s returns.
REQ-024 BIAS_ERR_O SHALL clear only on the next accepted request (clear wins over simultaneous set from previous state logic).
REQ-025 CFG_VALID_I while BUSY_O=1 SHALL be ignored (no capture, no queueing); request must be held until CFG_READY_O.
REQ-026 Counters SHALL saturate-free count up from 0 and compare to parameter-1; widths 8 bits (settle) and 16 bits (timeout).

Reset
REQ-027 While RSTN_I=0 at a clock edge: state ACTIVE, DS_O=00, SR_O=0, CO_O=0, DO_O=0, OE_O=0, ODP_O=0, ODN_O=0, BIAS_ERR_O=0, BUSY_O=0, CFG_READY_O=1, counters 0, sync flops 0.
REQ-028 Reset asserted mid-reconfiguration SHALL abandon the request; outputs take reset values on the next edge.

Structure
REQ-029 Package gpo_pad_ctrl_pkg SHALL hold the FSM state enum, mode encoding constants and DS encoding constants.
REQ-030 The two-flop synchroniser SHALL be a sub-module gpo_sync2 (reset to 0).

Verification
REQ-031 Reset release, EN_I=1, DATA_I toggling, DS=00 -> OE_O=1 and DO_O follows DATA_I one cycle later.
REQ-032 Request DS=10 push-pull, BIAS_OK_I=1, SETTLE_CYC=4 -> OE_O low 4+1+2-sync+4 cycles, DS_O=10 at APPLY, READY returns, no error.
REQ-033 Request DS=11, BIAS_OK_I=0, BIAS_TO=16 -> DS_O=11 for 16 cycles then 00, BIAS_ERR_O=1, next request clears it.
REQ-034 ACTIVE with DS=01, drop BIAS_OK_I -> OE_O=0 three cycles later, BIAS_ERR_O=1; restore -> OE_O=1 three cycles after.
REQ-035 Mode 01 and 11 requests -> ODP_O/ODN_O = 1/0 and 1/1; CFG_VALID_I during BUSY_O ignored.
REQ-036 Assert RSTN_I=0 in WAIT_BIAS -> all outputs reset values next edge, CFG_READY_O=1.
